// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OS_RATE   = 16;
  localparam int MID_START = OS_RATE / 2 - 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start/data/stop sequencing that
// strobes each data bit out to an external serial-in shift register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  output logic bit_out,
  output logic shift,
  output logic rx_done_tick,
  output logic frame_err,
  output logic busy
);
  // Tick counter must reach both the data-bit length and the stop length.
  localparam int TW = cnt_w((SB_TICK > OS_RATE) ? SB_TICK : OS_RATE);
  localparam int BW = cnt_w(DBIT);

  localparam logic [TW-1:0] T_MID  = TW'(MID_START);
  localparam logic [TW-1:0] T_BIT  = TW'(OS_RATE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  rx_state_t       state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic            rx_s;
  logic            bit_out_n, shift_n, done_n, ferr_n, busy_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      bit_cnt      <= '0;
      bit_out      <= 1'b0;
      shift        <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      tick         <= tick_n;
      bit_cnt      <= bit_n;
      bit_out      <= bit_out_n;
      shift        <= shift_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick == T_MID) begin
            // A start bit that is high again by mid-bit was a glitch.
            if (!rx_s) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick == T_BIT) begin
            tick_n = '0;
            if (bit_cnt == B_LAST) state_n = STOP;
            else                   bit_n   = bit_cnt + 1'b1;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick == T_STOP) state_n = IDLE;
          else                tick_n  = tick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bit_out_n = bit_out;
    shift_n   = 1'b0;
    done_n    = 1'b0;
    ferr_n    = frame_err;
    busy_n    = (state_n != IDLE);
    if (state == DATA && s_tick && tick == T_BIT) begin
      bit_out_n = rx_s;
      shift_n   = 1'b1;
    end
    if (state == STOP && s_tick && tick == T_STOP) begin
      done_n = 1'b1;
      ferr_n = ~rx_s;
    end
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame, LSB first; legal range 5..9.
REQ-002 Parameter SB_TICK, default 16: oversample ticks spanned by the stop bit (16/24/32 = 1/1.5/2 stop bits).
REQ-003 Port clk  input  1  system clock; all logic rising-edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx  input  1  asynchronous serial line; idle high.
REQ-006 Port s_tick  input  1  one-clk enable pulse at 16x baud rate.
REQ-007 Port bit_out  output  1  sampled data bit; valid while shift=1.
REQ-008 Port shift  output  1  one-clk strobe; feeds the serial-in/parallel-out shift register's shift input.
REQ-009 Port rx_done_tick  output  1  one-clk pulse at end of stop bit.
REQ-010 Port frame_err  output  1  stop bit sampled low in last frame; held until next rx_done_tick.
REQ-011 Port busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; tick counter 4 bits (0..SB_TICK-1 in STOP, so width = clog2(SB_TICK)); bit counter clog2(DBIT) bits.
REQ-014 IDLE: rx_s=0 -> START, tick counter cleared; s_tick not required.
REQ-015 START: on s_tick with counter=7 (mid start bit): rx_s=0 -> DATA, counters cleared; rx_s=1 -> IDLE (glitch rejected, no outputs); otherwise counter increments on s_tick.
REQ-016 DATA: on s_tick with counter=15: counter cleared, bit_out<=rx_s and shift<=1 for exactly one clk in the cycle following that clock edge; bit counter=DBIT-1 -> STOP, else bit counter increments.
REQ-017 STOP: on s_tick with counter=SB_TICK-1: rx_done_tick=1 for one clk, frame_err<=~rx_s in the same cycle, -> IDLE.
REQ-018 Exactly DBIT shift pulses SHALL precede each rx_done_tick; shift and rx_done_tick SHALL never be high together.
REQ-019 Counters SHALL advance only on s_tick; clocks without s_tick hold all state.
REQ-020 rx_s=0 on the same cycle that IDLE is re-entered SHALL start a new frame on the next clk (back-to-back frames, no dead ticks required).
REQ-021 bit_out SHALL hold its last value when shift=0.

Reset
REQ-022 reset SHALL force: state IDLE, all counters 0, synchronizer flops 1, bit_out 0, shift 0, rx_done_tick 0, frame_err 0, busy 0.
REQ-023 reset mid-frame SHALL abort the frame with no further shift or rx_done_tick pulses; reset has priority over s_tick.

Structure
REQ-024 Package uart_pkg SHALL hold typedef rx_state_t (IDLE, START, DATA, STOP) and constant OS_RATE=16; mid-start sample point derived as OS_RATE/2-1.
REQ-025 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameterizable, here 1); no other sub-modules.
REQ-026 All outputs SHALL be registered.

Verification
REQ-027 Bench: s_tick every 4 clks (bit = 64 clks), downstream shift register M=DBIT attached.
REQ-028 Frame 0xA5, stop=1 -> shift pulses with bit_out 1,0,1,0,0,1,0,1; one rx_done_tick; frame_err=0; shift register holds 0xA5.
REQ-029 rx low for 4 ticks then high -> return to IDLE at tick 8, no shift, no rx_done_tick, busy drops.
REQ-030 Frame 0x3C with stop=0 -> 8 shifts, rx_done_tick, frame_err=1; next valid frame 0x01 -> frame_err=0.
REQ-031 reset asserted after 3rd shift pulse of frame 0xFF -> all outputs 0 next clk, no rx_done_tick; following frame 0x5A received correctly.
REQ-032 Back-to-back frames 0x00 then 0xFF, one stop bit, no idle gap -> 16 shifts, 2 rx_done_tick pulses, register values 0x00 then 0xFF.
REQ-033 DBIT=5, SB_TICK=32, frame 5'b10110 -> 5 shifts (0,1,1,0,1), rx_done_tick 32 ticks after 5th sample.
